// File: rtl/boid_frame_sequencer_if.sv
// Bundle for boid_frame_sequencer: host control, M10K read/write ports and datapath record links.
// master = sequencer side; slave = the memory/datapath/host environment.
interface boid_frame_sequencer_if #(
    parameter int unsigned AW = 5
);
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    logic [AW:0] mem_raddr;
    logic [31:0] mem_rdata_x;
    logic [31:0] mem_rdata_y;
    logic [31:0] mem_rdata_vx;
    logic [31:0] mem_rdata_vy;

    logic        mem_we;
    logic [AW:0] mem_waddr;
    logic [31:0] mem_wdata_x;
    logic [31:0] mem_wdata_y;
    logic [31:0] mem_wdata_vx;
    logic [31:0] mem_wdata_vy;

    logic        r_en_tot;
    logic        r_en_itr;
    logic [6:0]  wb_en;
    logic [31:0] x_in_xcel;
    logic [31:0] y_in_xcel;
    logic [31:0] vx_in_xcel;
    logic [31:0] vy_in_xcel;
    logic [31:0] x_out_xcel;
    logic [31:0] y_out_xcel;
    logic [31:0] vx_out_xcel;
    logic [31:0] vy_out_xcel;

    modport master (
        input  start, mem_rdata_x, mem_rdata_y, mem_rdata_vx, mem_rdata_vy,
               x_out_xcel, y_out_xcel, vx_out_xcel, vy_out_xcel,
        output busy, done, frame_cnt, mem_raddr, mem_we, mem_waddr,
               mem_wdata_x, mem_wdata_y, mem_wdata_vx, mem_wdata_vy,
               r_en_tot, r_en_itr, wb_en, x_in_xcel, y_in_xcel, vx_in_xcel, vy_in_xcel
    );

    modport slave (
        output start, mem_rdata_x, mem_rdata_y, mem_rdata_vx, mem_rdata_vy,
               x_out_xcel, y_out_xcel, vx_out_xcel, vy_out_xcel,
        input  busy, done, frame_cnt, mem_raddr, mem_we, mem_waddr,
               mem_wdata_x, mem_wdata_y, mem_wdata_vx, mem_wdata_vy,
               r_en_tot, r_en_itr, wb_en, x_in_xcel, y_in_xcel, vx_in_xcel, vy_in_xcel
    );
endinterface

// File: rtl/boid_frame_sequencer.sv
// Per-frame boid sequencer: for each self boid, streams self then all boids into the
// datapath, writes the updated record to the opposite bank, and swaps banks at frame end.
module boid_frame_sequencer #(
    parameter int unsigned N_BOIDS = 32,
    parameter int unsigned AW      = $clog2(N_BOIDS)
) (
    input logic                    clk,
    input logic                    reset,
    boid_frame_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        StIdle, StSelfRd, StSelfLat, StIter, StWbSettle, StWbWrite, StDone
    } state_e;

    localparam logic [AW-1:0] LastIdx = AW'(N_BOIDS - 1);
    localparam logic [AW-1:0] OneIdx  = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [AW-1:0] k_q, k_d;
    logic          rbank_q, rbank_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [AW-1:0] k_inc;

    assign k_inc         = k_q + OneIdx;
    assign bus.frame_cnt = frame_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            i_q         <= '0;
            k_q         <= '0;
            rbank_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            k_q         <= k_d;
            rbank_q     <= rbank_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        i_d              = i_q;
        k_d              = k_q;
        rbank_d          = rbank_q;
        frame_cnt_d      = frame_cnt_q;
        bus.busy         = (state_q != StIdle);
        bus.done         = 1'b0;
        bus.mem_raddr    = '0;
        bus.mem_we       = 1'b0;
        bus.mem_waddr    = '0;
        bus.mem_wdata_x  = '0;
        bus.mem_wdata_y  = '0;
        bus.mem_wdata_vx = '0;
        bus.mem_wdata_vy = '0;
        bus.r_en_tot     = 1'b0;
        bus.r_en_itr     = 1'b0;
        bus.wb_en        = '0;
        bus.x_in_xcel    = '0;
        bus.y_in_xcel    = '0;
        bus.vx_in_xcel   = '0;
        bus.vy_in_xcel   = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StSelfRd;
                    i_d     = '0;
                end
            end
            StSelfRd: begin
                bus.mem_raddr = {rbank_q, i_q};
                state_d       = StSelfLat;
            end
            StSelfLat: begin
                bus.r_en_tot   = 1'b1;
                bus.x_in_xcel  = bus.mem_rdata_x;
                bus.y_in_xcel  = bus.mem_rdata_y;
                bus.vx_in_xcel = bus.mem_rdata_vx;
                bus.vy_in_xcel = bus.mem_rdata_vy;
                // Prefetch neighbour 0 so it is on the read port during the first ITER cycle.
                bus.mem_raddr  = {rbank_q, {AW{1'b0}}};
                k_d            = '0;
                state_d        = StIter;
            end
            StIter: begin
                bus.x_in_xcel  = bus.mem_rdata_x;
                bus.y_in_xcel  = bus.mem_rdata_y;
                bus.vx_in_xcel = bus.mem_rdata_vx;
                bus.vy_in_xcel = bus.mem_rdata_vy;
                bus.r_en_itr   = (k_q != i_q);
                bus.mem_raddr  = {rbank_q, k_inc};
                if (k_q == LastIdx) begin
                    state_d = StWbSettle;
                end else begin
                    k_d = k_inc;
                end
            end
            StWbSettle: begin
                bus.wb_en = 7'h01;
                state_d   = StWbWrite;
            end
            StWbWrite: begin
                bus.wb_en        = 7'h01;
                bus.mem_we       = 1'b1;
                bus.mem_waddr    = {~rbank_q, i_q};
                bus.mem_wdata_x  = bus.x_out_xcel;
                bus.mem_wdata_y  = bus.y_out_xcel;
                bus.mem_wdata_vx = bus.vx_out_xcel;
                bus.mem_wdata_vy = bus.vy_out_xcel;
                if (i_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    i_d     = i_q + OneIdx;
                    state_d = StSelfRd;
                end
            end
            StDone: begin
                bus.done    = 1'b1;
                rbank_d     = ~rbank_q;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_boid_frame_sequencer.sv
// Directed bench for boid_frame_sequencer with N_BOIDS=4, a registered two-bank memory
// model and a stub datapath whose outputs encode self index, self y and neighbour count.
module tb_boid_frame_sequencer;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 2;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   bad_wdata;

    boid_frame_sequencer_if #(.AW(AW)) bus ();

    boid_frame_sequencer #(.N_BOIDS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered two-bank memory: word index = {bank, boid}.
    logic [31:0] mx [0:7];
    logic [31:0] my [0:7];
    logic [31:0] mvx[0:7];
    logic [31:0] mvy[0:7];
    logic [31:0] rdx, rdy, rdvx, rdvy;

    always @(posedge clk) begin
        rdx  <= mx[bus.mem_raddr];
        rdy  <= my[bus.mem_raddr];
        rdvx <= mvx[bus.mem_raddr];
        rdvy <= mvy[bus.mem_raddr];
        if (bus.mem_we) begin
            mx[bus.mem_waddr]  <= bus.mem_wdata_x;
            my[bus.mem_waddr]  <= bus.mem_wdata_y;
            mvx[bus.mem_waddr] <= bus.mem_wdata_vx;
            mvy[bus.mem_waddr] <= bus.mem_wdata_vy;
        end
    end

    assign bus.mem_rdata_x  = rdx;
    assign bus.mem_rdata_y  = rdy;
    assign bus.mem_rdata_vx = rdvx;
    assign bus.mem_rdata_vy = rdvy;

    // Stub datapath: x = 0x50000 + self order, y = self y + 1, vx = self vx + neighbours seen.
    logic [31:0] sidx, tot_cnt, sy, svx, acc;
    always @(posedge clk) begin
        if (!reset) begin
            tot_cnt <= 0;
            sidx    <= 0;
            sy      <= 0;
            svx     <= 0;
            acc     <= 0;
        end else if (bus.r_en_tot) begin
            sidx    <= tot_cnt;
            tot_cnt <= tot_cnt + 1;
            sy      <= bus.y_in_xcel;
            svx     <= bus.vx_in_xcel;
            acc     <= 0;
        end else begin
            if (bus.r_en_itr) acc <= acc + 1;
            if (bus.done) tot_cnt <= 0;
        end
    end

    assign bus.x_out_xcel  = 32'h0005_0000 + sidx;
    assign bus.y_out_xcel  = sy + 32'd1;
    assign bus.vx_out_xcel = svx + acc;
    assign bus.vy_out_xcel = 32'hCAFE_0000 | sidx;

    logic [2:0]  c_raddr[0:39];
    logic [2:0]  c_waddr[0:39];
    logic        c_busy [0:39];
    logic        c_done [0:39];
    logic        c_tot  [0:39];
    logic        c_itr  [0:39];
    logic        c_we   [0:39];
    logic [6:0]  c_wb   [0:39];
    logic [31:0] c_xin  [0:39];
    logic [15:0] c_fc   [0:39];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample n cycles at the falling edge; optionally drop start or pulse it for one cycle.
    task automatic capture(input int n, input int lo_at, input int pulse_at);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            c_raddr[c] = bus.mem_raddr;
            c_waddr[c] = bus.mem_waddr;
            c_busy[c]  = bus.busy;
            c_done[c]  = bus.done;
            c_tot[c]   = bus.r_en_tot;
            c_itr[c]   = bus.r_en_itr;
            c_we[c]    = bus.mem_we;
            c_wb[c]    = bus.wb_en;
            c_xin[c]   = bus.x_in_xcel;
            c_fc[c]    = bus.frame_cnt;
            if (!bus.mem_we && ((bus.mem_wdata_x | bus.mem_wdata_y |
                                 bus.mem_wdata_vx | bus.mem_wdata_vy) != 0))
                bad_wdata++;
            if (c == lo_at) bus.start = 1'b0;
            if (c == pulse_at) bus.start = 1'b1;
            if (pulse_at >= 0 && c == pulse_at + 1) bus.start = 1'b0;
        end
    endtask

    int n_busy, n_done, n_tot, n_itr, n_we, n_wb, w_idx;
    logic [2:0]  exp_ra[0:5];
    logic        exp_itr[0:3];

    initial begin
        errors    = 0;
        checks    = 0;
        bad_wdata = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            mx[j]      = j << 16;
            my[j]      = j;
            mvx[j]     = 32'h10 + j;
            mvy[j]     = 32'h20 + j;
            mx[4 + j]  = 32'hDEAD_0000;
            my[4 + j]  = 32'hDEAD_0000;
            mvx[4 + j] = 32'hDEAD_0000;
            mvy[4 + j] = 32'hDEAD_0000;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_raddr", bus.mem_raddr, 0);
        check("rst_wb_en", bus.wb_en, 0);
        check("rst_frame_cnt", bus.frame_cnt, 0);
        reset = 1'b1;

        // Frame A: single start pulse, bank 0 -> bank 1
        @(negedge clk);
        bus.start = 1'b1;
        capture(34, 0, -1);
        n_busy = 0; n_done = 0; n_tot = 0; n_itr = 0; n_we = 0; n_wb = 0; w_idx = 0;
        for (int c = 0; c < 34; c++) begin
            n_busy += int'(c_busy[c]);
            n_done += int'(c_done[c]);
            n_tot  += int'(c_tot[c]);
            n_itr  += int'(c_itr[c]);
            n_wb   += int'(c_wb[c] != 0);
            if (c_we[c]) begin
                check("A_waddr", c_waddr[c], 4 + w_idx);
                w_idx++;
            end
        end
        check("A_done_at_32", c_done[32], 1);
        check("A_done_count", n_done, 1);
        check("A_busy_count", n_busy, 33);
        check("A_busy_after", c_busy[33], 0);
        check("A_r_en_tot", n_tot, 4);
        check("A_r_en_itr", n_itr, 12);
        check("A_mem_we", w_idx, 4);
        check("A_wb_cycles", n_wb, 8);
        check("A_wb_en_val", c_wb[14], 7'h01);
        check("A_fc_before", c_fc[32], 0);
        check("A_fc_after", c_fc[33], 1);
        exp_ra[0] = 3'd2; exp_ra[1] = 3'd0; exp_ra[2] = 3'd1;
        exp_ra[3] = 3'd2; exp_ra[4] = 3'd3; exp_ra[5] = 3'd0;
        exp_itr[0] = 1'b1; exp_itr[1] = 1'b1; exp_itr[2] = 1'b0; exp_itr[3] = 1'b1;
        for (int s = 0; s < 6; s++) check("A_i2_raddr", c_raddr[16 + s], exp_ra[s]);
        for (int s = 0; s < 4; s++) check("A_i2_itr", c_itr[18 + s], exp_itr[s]);
        check("A_i2_self_x", c_xin[17], 32'h0002_0000);
        for (int j = 0; j < 4; j++) begin
            check("A_bank1_x", mx[4 + j], 32'h0005_0000 + j);
            check("A_bank1_y", my[4 + j], j + 1);
            check("A_bank1_vx", mvx[4 + j], 32'h10 + j + 3);
            check("A_bank1_vy", mvy[4 + j], 32'hCAFE_0000 | j);
            check("A_bank0_kept", mx[j], j << 16);
        end

        // Frame B: start held high through DONE, bank 1 -> bank 0, then frame C auto-starts
        @(negedge clk);
        bus.start = 1'b1;
        capture(35, 34, -1);
        for (int i = 0; i < 4; i++) begin
            check("B_self_raddr", c_raddr[8 * i], 4 + i);
            check("B_lat_raddr", c_raddr[8 * i + 1], 4);
            check("B_we", c_we[8 * i + 7], 1);
            check("B_waddr", c_waddr[8 * i + 7], i);
        end
        check("B_done_at_32", c_done[32], 1);
        check("B_idle_after", c_busy[33], 0);
        check("B_fc", c_fc[33], 2);
        check("B_restart", c_busy[34], 1);
        check("B_restart_raddr", c_raddr[34], 0);
        for (int j = 0; j < 4; j++) begin
            check("B_bank0_x", mx[j], 32'h0005_0000 + j);
            check("B_bank0_y", my[j], j + 2);
        end

        // Frame C: already in its first cycle; a one-cycle start pulse during ITER is ignored
        capture(33, -1, 3);
        n_done = 0;
        for (int c = 0; c < 33; c++) n_done += int'(c_done[c]);
        check("C_done_at_31", c_done[31], 1);
        check("C_done_count", n_done, 1);
        check("C_idle_after", c_busy[32], 0);
        check("C_fc", c_fc[32], 3);
        capture(10, -1, -1);
        n_busy = 0;
        for (int c = 0; c < 10; c++) n_busy += int'(c_busy[c]);
        check("C_no_queued_frame", n_busy, 0);
        check("C_fc_unchanged", c_fc[9], 3);

        // Reset mid-ITER: read bank is 1 at this point
        bus.start = 1'b1;
        capture(4, 0, -1);
        check("R_pre_raddr", c_raddr[0], 4);
        reset = 1'b0;
        #1;
        check("R_busy", bus.busy, 0);
        check("R_itr", bus.r_en_itr, 0);
        check("R_tot", bus.r_en_tot, 0);
        check("R_raddr", bus.mem_raddr, 0);
        check("R_xin", bus.x_in_xcel, 0);
        check("R_we", bus.mem_we, 0);
        check("R_waddr", bus.mem_waddr, 0);
        check("R_wdata", bus.mem_wdata_x, 0);
        check("R_wb_en", bus.wb_en, 0);
        check("R_fc", bus.frame_cnt, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        capture(3, -1, -1);
        n_busy = 0; n_we = 0;
        for (int c = 0; c < 3; c++) begin
            n_busy += int'(c_busy[c]);
            n_we   += int'(c_we[c]);
        end
        check("R_post_busy", n_busy, 0);
        check("R_post_we", n_we, 0);
        check("R_post_raddr", c_raddr[0], 0);
        check("R_post_fc", c_fc[0], 0);

        bus.start = 1'b1;
        capture(34, 0, -1);
        check("R2_raddr_bank0", c_raddr[0], 0);
        check("R2_raddr_i1", c_raddr[8], 1);
        check("R2_waddr", c_waddr[7], 4);
        check("R2_we", c_we[7], 1);
        check("R2_done", c_done[32], 1);
        check("R2_fc", c_fc[33], 1);

        check("wdata_gating", bad_wdata, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/boid_frame_sequencer.md
# boid_frame_sequencer

Frame-level sequencer that sits between the double-buffered boid state memory (M10K, x/y/vx/vy words per boid) and the boid accelerator datapath. Each frame, for every boid i, it streams boid i's state into the datapath as the "self" record, then streams every other boid as neighbours, and writes the datapath's updated x/y/vx/vy back to the opposite memory bank. One `start` pulse runs one full frame; banks swap at frame end.

## Interface
Parameters:
- `N_BOIDS`, 32, boids per frame; power of two, 2..64
- `AW`, $clog2(N_BOIDS), boid index width

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin one frame; sampled only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle
- `done`  out  1  one-cycle pulse in DONE state
- `frame_cnt`  out  16  completed frames, wraps at 0xFFFF→0
- `mem_raddr`  out  AW+1  {read bank, boid index}; registered M10K, data valid next cycle
- `mem_rdata_x`, `mem_rdata_y`, `mem_rdata_vx`, `mem_rdata_vy`  in  32 each  read data
- `mem_we`  out  1  write strobe
- `mem_waddr`  out  AW+1  {~read bank, i}
- `mem_wdata_x`, `mem_wdata_y`, `mem_wdata_vx`, `mem_wdata_vy`  out  32 each  write data
- `r_en_tot`  out  1  datapath: latch self record, clear accumulators
- `r_en_itr`  out  1  datapath: accumulate current neighbour
- `wb_en`  out  7  datapath writeback enable; only bit 0 used, bits 6:1 tied 0
- `x_in_xcel`, `y_in_xcel`, `vx_in_xcel`, `vy_in_xcel`  out  32 each  record to datapath
- `x_out_xcel`, `y_out_xcel`, `vx_out_xcel`, `vy_out_xcel`  in  32 each  updated record from datapath (combinational)

## Operation
- Registers: state, `i` (self index, AW), `k` (neighbour index, AW), `rbank` (1), `frame_cnt` (16).
- States, one cycle each unless noted:
  - IDLE: `start`=1 → SELF_RD, `i`←0.
  - SELF_RD: `mem_raddr`={rbank,i}. → SELF_LAT.
  - SELF_LAT: `r_en_tot`=1; `*_in_xcel` = `mem_rdata_*` (boid i); `mem_raddr`={rbank,0}; `k`←0. → ITER.
  - ITER (N_BOIDS cycles): `mem_rdata_*` holds boid k; `*_in_xcel` = `mem_rdata_*`; `r_en_itr` = (k≠i); `mem_raddr`={rbank,k+1} (wraps to 0 at k=N−1, don't-care). k=N−1 → WB_SETTLE, else k++.
  - WB_SETTLE: `wb_en`=7'h01. → WB_WRITE.
  - WB_WRITE: `wb_en`=7'h01, `mem_we`=1, `mem_waddr`={~rbank,i}, `mem_wdata_*` = `*_out_xcel`. i=N−1 → DONE, else i++ → SELF_RD.
  - DONE: `done`=1, `rbank` toggles, `frame_cnt`++. → IDLE.
- Gating: `*_in_xcel` = 0 outside SELF_LAT/ITER; `mem_wdata_*` = 0 when `mem_we`=0; `wb_en` = 0 outside WB states.
- Reads never target the write bank within a frame; all boids update from the same snapshot.
- `start` outside IDLE ignored (no queuing).

## Timing
- Reset (async assert, any state): state IDLE, i=k=0, rbank=0, frame_cnt=0; all outputs 0 (`busy`, `done`, `mem_we`, `r_en_*`, `wb_en`, addresses, data).
- Reset mid-frame: no further `mem_we`; partially written bank is abandoned; next `start` reads bank 0.
- Per boid: N_BOIDS+4 cycles. `start` sampled at edge E0 → `done` high in the cycle after edge E0+N·(N+4); `busy` high from E0 through that cycle.
- Read-to-use latency 1 cycle; address issued the cycle before the record is presented to the datapath.
- `start` in DONE cycle ignored; `start` in the IDLE cycle after DONE accepted.
- `frame_cnt` and `rbank` update on the same edge leaving DONE.

## Test plan
- Reset: drive `reset`=0 mid-ITER with N_BOIDS=4 → same cycle all outputs 0; after release, `busy`=0, `mem_raddr`=0, `frame_cnt`=0.
- Full frame, N_BOIDS=4, memory bank 0 preloaded x=j<<16: `start` pulse → `done` 32 edges later; exactly 4 `r_en_tot`, 12 `r_en_itr`, 4 `mem_we` at waddr 4,5,6,7 (bank 1).
- Self skip, N_BOIDS=4, i=2: `mem_raddr` sequence {0,2},{0,0},{0,1},{0,2},{0,3},{0,0}; `r_en_itr` = 1,1,0,1 during ITER; `x_in_xcel` in SELF_LAT = 2<<16.
- Writeback data: stub datapath returns x_out=0x00050000+i → bank 1 word i holds that value; `mem_wdata_*`=0 on all non-write cycles.
- Bank swap: two back-to-back frames → second frame reads addresses 4..7, writes 0..3; `frame_cnt`=2.
- `start` held high through frame 1 → frame 2 begins in the cycle after DONE's IDLE; single pulse during ITER → ignored, `frame_cnt` unchanged.
